// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: XNOR step function, checker FSM states and default taps.
// Used by both the generator and lfsr_checker.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 32;
    localparam logic [3:0] DEFAULT_TAPS = 4'b1100;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Operands are zero-extended to LFSR_MAX_W; bits at or above width are cleared.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    width
    );
        logic                  fb;
        logic [LFSR_MAX_W-1:0] r;
        fb = ~^(s & taps);
        r  = {s[LFSR_MAX_W-2:0], fb};
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i >= width) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for an XNOR LFSR word stream (HUNT -> CHECK -> LOCKED).
// Define LFSR_CHECKER_ERR_CNT_EN to build the saturating error counter; otherwise err_cnt is 0.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned                  OUTPUT_WIDTH  = 4,
    parameter logic [OUTPUT_WIDTH-1:0]      TAPS          = DEFAULT_TAPS,
    parameter int unsigned                  LOCK_COUNT    = 4,
    parameter int unsigned                  UNLOCK_COUNT  = 4,
    parameter int unsigned                  ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    input  logic [OUTPUT_WIDTH-1:0]  data_in,
    output logic                     locked,
    output logic                     err,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [OUTPUT_WIDTH-1:0]  expected,
    output chk_state_t               dbg_state
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [MW-1:0]           LOCK_LAST   = MW'(LOCK_COUNT - 1);
    localparam logic [UW-1:0]           UNLOCK_LAST = UW'(UNLOCK_COUNT - 1);
    localparam logic [OUTPUT_WIDTH-1:0] LOCKUP      = '1;

    function automatic logic [OUTPUT_WIDTH-1:0] step_word(input logic [OUTPUT_WIDTH-1:0] s);
        logic [LFSR_MAX_W-1:0] s_ext;
        logic [LFSR_MAX_W-1:0] t_ext;
        logic [LFSR_MAX_W-1:0] r;
        s_ext = '0;
        s_ext[OUTPUT_WIDTH-1:0] = s;
        t_ext = '0;
        t_ext[OUTPUT_WIDTH-1:0] = TAPS;
        r = lfsr_next(s_ext, t_ext, int'(OUTPUT_WIDTH));
        return r[OUTPUT_WIDTH-1:0];
    endfunction

    chk_state_t              state_q, state_d;
    logic [OUTPUT_WIDTH-1:0] expected_q, expected_d;
    logic [MW-1:0]           match_cnt_q, match_cnt_d;
    logic [UW-1:0]           miss_cnt_q, miss_cnt_d;
    logic                    err_q, err_d;
    logic                    locked_q, locked_d;
    logic                    err_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        err_inc     = 1'b0;
        if (enb) begin
            case (state_q)
                HUNT: begin
                    if (data_in != LOCKUP) begin
                        expected_d  = step_word(data_in);
                        match_cnt_d = '0;
                        state_d     = CHECK;
                    end
                end
                CHECK: begin
                    if (data_in == expected_q) begin
                        expected_d = step_word(expected_q);
                        if (match_cnt_q == LOCK_LAST) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else if (data_in == LOCKUP) begin
                        state_d     = HUNT;
                        match_cnt_d = '0;
                    end else begin
                        expected_d  = step_word(data_in);
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running prediction: received words never reseed once locked.
                    expected_d = step_word(expected_q);
                    if (data_in == expected_q) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        if (miss_cnt_q == UNLOCK_LAST) begin
                            state_d    = HUNT;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

`ifdef LFSR_CHECKER_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
    assign err_cnt        = '0;
`endif

    assign locked    = locked_q;
    assign err       = err_q;
    assign expected  = expected_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed LFSR streams, corruption, unlock, enable gaps,
// async reset and a 2-bit saturating counter instance.
module tb_lfsr_checker;
    import lfsr_pkg::*;

`ifdef LFSR_CHECKER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Packed expectation: {state[25:24], locked[23], err[22], expected[21:18], cnt16[17:2], cnt2[1:0]}
    localparam int EW = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b0;
    logic [3:0]  data_in = 4'd0;

    logic        locked, locked2;
    logic        err, err2;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;
    logic [3:0]  expected, expected2;
    chk_state_t  dbg_state, dbg_state2;

    logic [3:0] seq [15] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110,
                             4'b1101, 4'b1011, 4'b0110, 4'b1100, 4'b1001,
                             4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000};

    logic [EW-1:0] exp_q[$];
    int            checks    = 0;
    int            errors    = 0;
    int            pos       = 0;
    int            err_total = 0;
    chk_state_t    last_st   = HUNT;
    logic [3:0]    last_ex   = 4'd0;

    lfsr_checker #(
        .OUTPUT_WIDTH(4), .TAPS(4'b1100), .LOCK_COUNT(4), .UNLOCK_COUNT(4), .ERR_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .enb(enb), .data_in(data_in),
        .locked(locked), .err(err), .err_cnt(err_cnt), .expected(expected),
        .dbg_state(dbg_state)
    );

    lfsr_checker #(
        .OUTPUT_WIDTH(4), .TAPS(4'b1100), .LOCK_COUNT(4), .UNLOCK_COUNT(4), .ERR_CNT_WIDTH(2)
    ) dut_sat (
        .clk(clk), .rst(rst), .enb(enb), .data_in(data_in),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2), .expected(expected2),
        .dbg_state(dbg_state2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Inputs are applied after an edge; the expectation is queued once the sampling edge passes.
    task automatic drive(input logic en, input logic [3:0] din, input chk_state_t st,
                         input logic er, input logic [3:0] ex);
        logic [15:0] c1;
        logic [1:0]  c2;
        enb     = en;
        data_in = din;
        @(posedge clk);
        if (er) err_total++;
        c1 = CNT_EN ? ((err_total > 65535) ? 16'hFFFF : 16'(err_total)) : 16'd0;
        c2 = CNT_EN ? ((err_total > 3) ? 2'd3 : 2'(err_total)) : 2'd0;
        exp_q.push_back({st, (st == LOCKED), er, ex, c1, c2});
        last_st = st;
        last_ex = ex;
        #1;
    endtask

    task automatic step(input logic [3:0] din, input chk_state_t st, input logic er);
        drive(1'b1, din, st, er, seq[(pos + 1) % 15]);
        pos++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_locked"},   32'(locked),    32'd0);
        check({tag, "_err"},      32'(err),       32'd0);
        check({tag, "_err_cnt"},  32'(err_cnt),   32'd0);
        check({tag, "_expected"}, 32'(expected),  32'd0);
        check({tag, "_state"},    32'(dbg_state), 32'(HUNT));
        check({tag, "_err_cnt2"}, 32'(err_cnt2),  32'd0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset_values("async_rst");
        #1 rst = 1'b0;
        enb = 1'b0;
        @(posedge clk);
        #1;
        err_total = 0;
        pos       = 0;
        last_st   = HUNT;
        last_ex   = 4'd0;
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",     32'(dbg_state), 32'(e[25:24]));
            check("locked",    32'(locked),    32'(e[23]));
            check("err",       32'(err),       32'(e[22]));
            check("expected",  32'(expected),  32'(e[21:18]));
            check("err_cnt",   32'(err_cnt),   32'(e[17:2]));
            check("err_cnt2",  32'(err_cnt2),  32'(e[1:0]));
            check("sat_err",   32'(err2),      32'(e[22]));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 check_reset_values("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean lock across several wraps
        for (int i = 0; i < 40; i++) step(seq[pos % 15], (i < 4) ? CHECK : LOCKED, 1'b0);

        // Single corruption: 0101 sent where 0110 is predicted
        for (int i = 0; i < 20; i++) begin
            if (i == 12) step(4'b0101, LOCKED, 1'b1);
            else         step(seq[pos % 15], LOCKED, 1'b0);
        end

        // Loss of lock on a stuck lockup word, then relock on a clean stream
        for (int m = 0; m < 4; m++) step(4'hF, (m == 3) ? HUNT : LOCKED, 1'b1);
        drive(1'b1, 4'hF, HUNT, 1'b0, last_ex);
        drive(1'b1, 4'hF, HUNT, 1'b0, last_ex);
        pos = 0;
        for (int j = 0; j < 10; j++) step(seq[pos % 15], (j < 4) ? CHECK : LOCKED, 1'b0);

        async_reset();

        // Enable gaps with garbage on idle cycles; one corrupt word followed by an idle cycle
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 1) begin
                drive(1'b0, 4'($urandom_range(0, 15)), last_st, 1'b0, last_ex);
            end else if (k == 20) begin
                step(seq[pos % 15] ^ 4'b0001, LOCKED, 1'b1);
            end else begin
                step(seq[pos % 15], ((k / 2) < 4) ? CHECK : LOCKED, 1'b0);
            end
        end

        // Unlock again, then exercise CHECK reseed and the CHECK -> HUNT exit
        for (int m = 0; m < 4; m++) step(4'hF, (m == 3) ? HUNT : LOCKED, 1'b1);
        drive(1'b1, 4'b0011, CHECK, 1'b0, 4'b0111);
        drive(1'b1, 4'b1110, CHECK, 1'b0, 4'b1101);
        drive(1'b1, 4'b1101, CHECK, 1'b0, 4'b1011);
        drive(1'b1, 4'hF,    HUNT,  1'b0, 4'b1011);
        drive(1'b0, 4'b0000, HUNT,  1'b0, 4'b1011);

        repeat (2) @(negedge clk);
        #1 check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side counterpart to `lfsr`. It consumes the parallel word stream produced by an `lfsr` instance, self-synchronises to it, and flags every word that deviates from the predicted sequence. It is used for board-level link and blinker-pattern integrity checks. It sits downstream of the generator (or of the link carrying its output) in the same clock domain.

## Interface
- `OUTPUT_WIDTH`, 4: word width; must equal the generator's width.
- `TAPS`, 4'b1100: feedback tap mask; bit i set means state bit i feeds the XNOR.
- `LOCK_COUNT`, 4: consecutive correct predictions required to declare lock (≥1).
- `UNLOCK_COUNT`, 4: consecutive mispredictions in LOCKED that drop lock (≥1).
- `ERR_CNT_WIDTH`, 16: width of the error counter.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enb` in 1: `data_in` is a valid sample this cycle.
- `data_in` in OUTPUT_WIDTH: received LFSR word.
- `locked` out 1: checker is synchronised.
- `err` out 1: one-cycle pulse, mismatch detected while LOCKED.
- `err_cnt` out ERR_CNT_WIDTH: saturating mismatch count since reset.
- `expected` out OUTPUT_WIDTH: word predicted for the next valid sample.

## Operation
- Step function (identical to `lfsr`): fb = ~^(s & TAPS); next(s) = {s[W-2:0], fb}. Lockup word is all-ones. With the defaults, the period is 15: 0000→0001→0011→0111→1110→1101→1011→0110→1100→1001→0010→0101→1010→0100→1000→0000.
- State machine: HUNT, CHECK, LOCKED. Every transition and register update occurs only on an edge with `enb`=1. With `enb`=0, all state holds.
- HUNT:
  - `data_in` ≠ lockup: `expected`←next(`data_in`), match_cnt←0, go to CHECK.
  - `data_in` = lockup: stay in HUNT.
- CHECK:
  - `data_in`=`expected`: `expected`←next(`expected`), match_cnt++. When this is the LOCK_COUNT-th match, go to LOCKED.
  - Mismatch: reseed with `expected`←next(`data_in`) and match_cnt←0. If `data_in` is lockup, go to HUNT instead.
  - No `err` pulses are generated in CHECK.
- LOCKED:
  - `expected`←next(`expected`) on every valid sample, independent of `data_in`, so a corrupted word never corrupts the prediction.
  - Match: miss_cnt←0.
  - Mismatch: `err`←1 for one cycle, `err_cnt`++ (saturating at all-ones), miss_cnt++. The UNLOCK_COUNT-th consecutive miss goes to HUNT.
- `locked` = (state==LOCKED), registered.

## Timing
- Reset values: `locked`=0, `err`=0, `err_cnt`=0, `expected`=0, state=HUNT, match_cnt=miss_cnt=0. Reset takes effect without a clock edge.
- `rst` dominates over `enb` on any edge. Reset mid-operation discards lock and counts.
- All outputs are registered. `err` and the `err_cnt` increment appear on the edge that samples the bad word (visible the following cycle). `err` is deasserted on the next edge regardless of `enb`.
- Lock latency: 1 seed sample + LOCK_COUNT matching samples. With defaults, `locked` rises on the 5th consecutive valid edge of a clean stream.
- Unlock latency: `locked` falls on the edge sampling the UNLOCK_COUNT-th consecutive miss. That edge also pulses `err`.
- Sequence wrap (1000→0000 for defaults) is an ordinary transition with no special handling.

## Configuration
- `LFSR_CHECKER_ERR_CNT_EN`:
  - Defined: `err_cnt` register and saturating counter are present as described.
  - Undefined: no counter logic; `err_cnt` is tied to 0. `err`, `locked` and `expected` are unchanged.

## Structure
- Shared package `lfsr_pkg`:
  - `lfsr_next` function (width, taps) used by both `lfsr` and `lfsr_checker`.
  - `chk_state_t` enum {HUNT, CHECK, LOCKED}.
  - Default TAPS constant.
- No sub-module. Prediction is the package function; the FSM and counters live in the single module.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `locked`=0, `err`=0, `err_cnt`=0, `expected`=0000 before the next edge.
- Clean lock: drive the sequence from 0000, `enb`=1 every cycle, 40 words → `locked`=1 after the 5th edge. `err` never pulses, including across the 1000→0000 wrap. `err_cnt`=0.
- Single corruption: while locked, send 0101 where 0110 is expected → one `err` pulse, `err_cnt`=1, `locked` stays 1. The following correct 1100 and later words produce no further errors.
- Enable gaps: same stream with `enb` toggling 1/0 and `data_in` garbage while `enb`=0 → identical lock point in valid samples, zero errors.
- Loss of lock: after lock, hold `data_in`=1111 with `enb`=1 → 4 `err` pulses, `err_cnt`=4, `locked` falls on the 4th. State stays HUNT while 1111 persists. Resuming a clean stream relocks after 5 valid samples.
- Saturation/config: with ERR_CNT_WIDTH=2 and 5 isolated errors → `err_cnt`=3. With `LFSR_CHECKER_ERR_CNT_EN` undefined → `err_cnt`=0 throughout, `err` pulses unchanged.
